// File: rtl/sp_mem_arb.sv
// Round-robin arbiter for two clients sharing one single-port RAM.
// After reset it optionally sweeps every RAM word to INIT_VALUE before granting requests.
module sp_mem_arb #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter bit                    INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,

    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_din,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_data,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_din,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_data,

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH:0]     init_addr;
    logic                    last_gnt;
    logic                    gnt0;
    logic                    gnt1;
    logic                    run_ok;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   din_q;

    assign p0_rsp_data  = mem_dout;
    assign p1_rsp_data  = mem_dout;
    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

    // Grant selection and RAM port mux; the port keeps its last address/data when idle.
    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = addr_q;
        mem_din    = din_q;
        run_ok     = (state == ST_RUN) && !rst;

        if (state == ST_INIT) begin
            mem_we   = !rst;
            mem_addr = init_addr[ADDR_WIDTH-1:0];
            mem_din  = INIT_VALUE;
            if (init_addr == LAST_ADDR) begin
                state_next = ST_RUN;
            end
        end else begin
            gnt0 = run_ok && p0_req_valid && (!p1_req_valid || last_gnt);
            gnt1 = run_ok && p1_req_valid && (!p0_req_valid || !last_gnt);
            if (gnt0) begin
                mem_we   = p0_req_we;
                mem_addr = p0_req_addr;
                mem_din  = p0_req_din;
            end else if (gnt1) begin
                mem_we   = p1_req_we;
                mem_addr = p1_req_addr;
                mem_din  = p1_req_din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= INIT_EN ? ST_INIT : ST_RUN;
            init_addr    <= '0;
            init_done    <= 1'b0;
            last_gnt     <= 1'b1;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
        end else begin
            state        <= state_next;
            addr_q       <= mem_addr;
            din_q        <= mem_din;
            p0_rsp_valid <= gnt0 && !p0_req_we;
            p1_rsp_valid <= gnt1 && !p1_req_we;
            if (state == ST_INIT) begin
                init_addr <= init_addr + (ADDR_WIDTH+1)'(1);
            end
            if (state_next == ST_RUN) begin
                init_done <= 1'b1;
            end
            if (gnt0) begin
                last_gnt <= 1'b0;
            end else if (gnt1) begin
                last_gnt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sp_mem_arb.sv
// Self-checking bench for sp_mem_arb on a 16-word RAM, with a read-first RAM model
// and a behavioural arbitration/memory model for randomized traffic.
module tb_sp_mem_arb;

    localparam int          AW   = 4;
    localparam int          DW   = 32;
    localparam logic [31:0] INIT = 32'hA5A5A5A5;

    logic          clk;
    logic          rst;
    logic          init_done;
    logic          p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_din, p0_rsp_data;
    logic          p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_din, p1_rsp_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    int checks;
    int passes;

    logic [DW-1:0] ram [16];

    sp_mem_arb #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .INIT_EN   (1'b1),
        .INIT_VALUE(INIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_done   (init_done),
        .p0_req_valid(p0_req_valid),
        .p0_req_ready(p0_req_ready),
        .p0_req_we   (p0_req_we),
        .p0_req_addr (p0_req_addr),
        .p0_req_din  (p0_req_din),
        .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_data (p0_rsp_data),
        .p1_req_valid(p1_req_valid),
        .p1_req_ready(p1_req_ready),
        .p1_req_we   (p1_req_we),
        .p1_req_addr (p1_req_addr),
        .p1_req_din  (p1_req_din),
        .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_data (p1_rsp_data),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout)
    );

    // Single-port RAM: registered read of the pre-write contents.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive(input bit v0, input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        p0_req_valid = v0; p0_req_we = we0; p0_req_addr = a0; p0_req_din = d0;
        p1_req_valid = v1; p1_req_we = we1; p1_req_addr = a1; p1_req_din = d1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'h3, 32'h0, 1'b1, 1'b0, 4'h4, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (init_done !== 1'b0) $display("[TB] FAIL reset_init_done: got %b expected 0", init_done); else passes++;
        checks++; if (mem_we !== 1'b0) $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); else passes++;
        checks++; if (p0_req_ready !== 1'b0) $display("[TB] FAIL reset_p0_ready: got %b expected 0", p0_req_ready); else passes++;
        checks++; if (p1_req_ready !== 1'b0) $display("[TB] FAIL reset_p1_ready: got %b expected 0", p1_req_ready); else passes++;
        checks++; if (p0_rsp_valid !== 1'b0) $display("[TB] FAIL reset_p0_rsp: got %b expected 0", p0_rsp_valid); else passes++;
        checks++; if (p1_rsp_valid !== 1'b0) $display("[TB] FAIL reset_p1_rsp: got %b expected 0", p1_rsp_valid); else passes++;
    endtask

    task automatic test_sweep();
        drive(1'b1, 1'b0, 4'h9, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (mem_we !== 1'b1) $display("[TB] FAIL sweep_we[%0d]: got %b expected 1", i, mem_we); else passes++;
            checks++; if (mem_addr !== 4'(i)) $display("[TB] FAIL sweep_addr[%0d]: got %0d expected %0d", i, mem_addr, i); else passes++;
            checks++; if (mem_din !== INIT) $display("[TB] FAIL sweep_din[%0d]: got %h expected %h", i, mem_din, INIT); else passes++;
            checks++; if (init_done !== 1'b0) $display("[TB] FAIL sweep_done_early[%0d]: got %b expected 0", i, init_done); else passes++;
            checks++; if (p0_req_ready !== 1'b0) $display("[TB] FAIL sweep_ready[%0d]: got %b expected 0", i, p0_req_ready); else passes++;
            @(posedge clk);
            #1;
        end
        checks++; if (init_done !== 1'b1) $display("[TB] FAIL sweep_done: got %b expected 1", init_done); else passes++;
        checks++; if (p0_req_ready !== 1'b1) $display("[TB] FAIL sweep_first_ready: got %b expected 1", p0_req_ready); else passes++;
        checks++; if (mem_we !== 1'b0) $display("[TB] FAIL sweep_we_after: got %b expected 0", mem_we); else passes++;
        checks++; if (mem_addr !== 4'h9) $display("[TB] FAIL sweep_read_addr: got %0d expected 9", mem_addr); else passes++;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        checks++; if (p0_rsp_valid !== 1'b1) $display("[TB] FAIL sweep_rsp_valid: got %b expected 1", p0_rsp_valid); else passes++;
        checks++; if (p0_rsp_data !== INIT) $display("[TB] FAIL sweep_rsp_data: got %h expected %h", p0_rsp_data, INIT); else passes++;
        checks++; if (p1_rsp_valid !== 1'b0) $display("[TB] FAIL sweep_p1_rsp: got %b expected 0", p1_rsp_valid); else passes++;
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 4'hC, 32'h12345678, 1'b0, 1'b0, 4'h0, 32'h0);
        #1;
        checks++; if (p0_req_ready !== 1'b1) $display("[TB] FAIL wr_ready: got %b expected 1", p0_req_ready); else passes++;
        checks++; if (mem_we !== 1'b1) $display("[TB] FAIL wr_we: got %b expected 1", mem_we); else passes++;
        checks++; if (mem_addr !== 4'hC) $display("[TB] FAIL wr_addr: got %h expected c", mem_addr); else passes++;
        checks++; if (mem_din !== 32'h12345678) $display("[TB] FAIL wr_din: got %h expected 12345678", mem_din); else passes++;
        @(posedge clk);
        #1;
        checks++; if (p0_rsp_valid !== 1'b0) $display("[TB] FAIL wr_no_rsp: got %b expected 0", p0_rsp_valid); else passes++;
        drive(1'b1, 1'b0, 4'hC, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        #1;
        checks++; if (mem_we !== 1'b0) $display("[TB] FAIL rd_we: got %b expected 0", mem_we); else passes++;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        checks++; if (p0_rsp_valid !== 1'b1) $display("[TB] FAIL rd_rsp_valid: got %b expected 1", p0_rsp_valid); else passes++;
        checks++; if (p0_rsp_data !== 32'h12345678) $display("[TB] FAIL rd_rsp_data: got %h expected 12345678", p0_rsp_data); else passes++;
        checks++; if (p1_rsp_valid !== 1'b0) $display("[TB] FAIL rd_p1_rsp: got %b expected 0", p1_rsp_valid); else passes++;
        @(posedge clk);
        #1;
        checks++; if (p0_rsp_valid !== 1'b0) $display("[TB] FAIL rd_rsp_one_cycle: got %b expected 0", p0_rsp_valid); else passes++;
    endtask

    task automatic test_contention();
        int cnt0;
        int cnt1;
        int prev;
        cnt0 = 0;
        cnt1 = 0;
        prev = -1;
        drive(1'b1, 1'b1, 4'h1, 32'h11, 1'b0, 1'b0, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 4'h2, 32'h22);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 4'h1, 32'h0, 1'b1, 1'b0, 4'h2, 32'h0);
        for (int k = 0; k <= 6; k++) begin
            if (p0_rsp_valid === 1'b1) cnt0++;
            if (p1_rsp_valid === 1'b1) cnt1++;
            checks++; if (p0_rsp_valid !== (prev == 0)) $display("[TB] FAIL cont_p0_rsp[%0d]: got %b expected %b", k, p0_rsp_valid, prev == 0); else passes++;
            checks++; if (p1_rsp_valid !== (prev == 1)) $display("[TB] FAIL cont_p1_rsp[%0d]: got %b expected %b", k, p1_rsp_valid, prev == 1); else passes++;
            if (prev >= 0) begin
                checks++; if (p0_rsp_data !== ((prev == 0) ? 32'h11 : 32'h22)) $display("[TB] FAIL cont_data[%0d]: got %h", k, p0_rsp_data); else passes++;
            end
            if (k == 6) break;
            #1;
            checks++; if (p0_req_ready !== (k % 2 == 0)) $display("[TB] FAIL cont_p0_gnt[%0d]: got %b expected %b", k, p0_req_ready, k % 2 == 0); else passes++;
            checks++; if (p1_req_ready !== (k % 2 == 1)) $display("[TB] FAIL cont_p1_gnt[%0d]: got %b expected %b", k, p1_req_ready, k % 2 == 1); else passes++;
            prev = k % 2;
            @(posedge clk);
            #1;
            if (k == 5) drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        end
        checks++; if (cnt0 != 3) $display("[TB] FAIL cont_p0_count: got %0d expected 3", cnt0); else passes++;
        checks++; if (cnt1 != 3) $display("[TB] FAIL cont_p1_count: got %0d expected 3", cnt1); else passes++;
    endtask

    task automatic test_mixed();
        drive(1'b1, 1'b1, 4'h5, 32'hDEAD, 1'b1, 1'b0, 4'h5, 32'h0);
        #1;
        checks++; if (p0_req_ready !== 1'b1) $display("[TB] FAIL mix_p0_first: got %b expected 1", p0_req_ready); else passes++;
        checks++; if (p1_req_ready !== 1'b0) $display("[TB] FAIL mix_p1_wait: got %b expected 0", p1_req_ready); else passes++;
        checks++; if (mem_we !== 1'b1) $display("[TB] FAIL mix_we: got %b expected 1", mem_we); else passes++;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h5, 32'h0);
        #1;
        checks++; if (p1_req_ready !== 1'b1) $display("[TB] FAIL mix_p1_second: got %b expected 1", p1_req_ready); else passes++;
        checks++; if (mem_addr !== 4'h5) $display("[TB] FAIL mix_addr: got %h expected 5", mem_addr); else passes++;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        checks++; if (p1_rsp_valid !== 1'b1) $display("[TB] FAIL mix_rsp_valid: got %b expected 1", p1_rsp_valid); else passes++;
        checks++; if (p1_rsp_data !== 32'hDEAD) $display("[TB] FAIL mix_rsp_data: got %h expected dead", p1_rsp_data); else passes++;
        checks++; if (p0_rsp_valid !== 1'b0) $display("[TB] FAIL mix_p0_rsp: got %b expected 0", p0_rsp_valid); else passes++;
    endtask

    task automatic test_random();
        logic [DW-1:0] mm [16];
        int            lg;
        int            g;
        bit            ev0, ev1, h0, h1, v0, v1, we0, we1, exp_we, addr_known;
        logic [DW-1:0] ed0, ed1, d0, d1;
        logic [AW-1:0] a0, a1, last_addr;
        ev0 = 0; ev1 = 0; h0 = 0; h1 = 0; addr_known = 0;
        v0 = 0; v1 = 0; we0 = 0; we1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        ed0 = '0; ed1 = '0; last_addr = '0;
        lg = 1;
        for (int i = 0; i < 16; i++) mm[i] = INIT;
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 40 && init_done !== 1'b1; n++) begin
            @(posedge clk);
            #1;
        end
        checks++; if (init_done !== 1'b1) $display("[TB] FAIL rand_init_timeout: got %b expected 1", init_done); else passes++;
        for (int c = 0; c < 300; c++) begin
            checks++; if (p0_rsp_valid !== ev0) $display("[TB] FAIL rand_p0_rsp[%0d]: got %b expected %b", c, p0_rsp_valid, ev0); else passes++;
            checks++; if (p1_rsp_valid !== ev1) $display("[TB] FAIL rand_p1_rsp[%0d]: got %b expected %b", c, p1_rsp_valid, ev1); else passes++;
            if (ev0) begin
                checks++; if (p0_rsp_data !== ed0) $display("[TB] FAIL rand_p0_data[%0d]: got %h expected %h", c, p0_rsp_data, ed0); else passes++;
            end
            if (ev1) begin
                checks++; if (p1_rsp_data !== ed1) $display("[TB] FAIL rand_p1_data[%0d]: got %h expected %h", c, p1_rsp_data, ed1); else passes++;
            end
            if (!h0) begin
                v0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
                a0 = 4'($urandom_range(0, 15)); d0 = $urandom;
            end
            if (!h1) begin
                v1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
                a1 = 4'($urandom_range(0, 15)); d1 = $urandom;
            end
            drive(v0, we0, a0, d0, v1, we1, a1, d1);
            #1;
            if (v0 && v1) g = (lg == 0) ? 1 : 0;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
            else          g = -1;
            exp_we = (g == 0) ? we0 : (g == 1) ? we1 : 1'b0;
            checks++; if (p0_req_ready !== (g == 0)) $display("[TB] FAIL rand_p0_ready[%0d]: got %b expected %b", c, p0_req_ready, g == 0); else passes++;
            checks++; if (p1_req_ready !== (g == 1)) $display("[TB] FAIL rand_p1_ready[%0d]: got %b expected %b", c, p1_req_ready, g == 1); else passes++;
            checks++; if (mem_we !== exp_we) $display("[TB] FAIL rand_we[%0d]: got %b expected %b", c, mem_we, exp_we); else passes++;
            if (g >= 0) begin
                checks++; if (mem_addr !== ((g == 0) ? a0 : a1)) $display("[TB] FAIL rand_addr[%0d]: got %h expected %h", c, mem_addr, (g == 0) ? a0 : a1); else passes++;
                if (exp_we) begin
                    checks++; if (mem_din !== ((g == 0) ? d0 : d1)) $display("[TB] FAIL rand_din[%0d]: got %h expected %h", c, mem_din, (g == 0) ? d0 : d1); else passes++;
                end
            end else if (addr_known) begin
                checks++; if (mem_addr !== last_addr) $display("[TB] FAIL rand_addr_hold[%0d]: got %h expected %h", c, mem_addr, last_addr); else passes++;
            end
            ev0 = (g == 0) && !we0;
            ev1 = (g == 1) && !we1;
            ed0 = mm[a0];
            ed1 = mm[a1];
            if (g == 0 && we0) mm[a0] = d0;
            if (g == 1 && we1) mm[a1] = d1;
            if (g >= 0) begin
                lg         = g;
                last_addr  = (g == 0) ? a0 : a1;
                addr_known = 1'b1;
            end
            h0 = v0 && (g != 0);
            h1 = v1 && (g != 1);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic test_reset_mid_sweep();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++; if (mem_addr !== 4'h7) $display("[TB] FAIL mid_pre_addr: got %0d expected 7", mem_addr); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) $display("[TB] FAIL mid_we: got %b expected 0", mem_we); else passes++;
        checks++; if (init_done !== 1'b0) $display("[TB] FAIL mid_done: got %b expected 0", init_done); else passes++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (mem_we !== 1'b1) $display("[TB] FAIL mid_sweep_we[%0d]: got %b expected 1", i, mem_we); else passes++;
            checks++; if (mem_addr !== 4'(i)) $display("[TB] FAIL mid_sweep_addr[%0d]: got %0d expected %0d", i, mem_addr, i); else passes++;
            checks++; if (init_done !== 1'b0) $display("[TB] FAIL mid_sweep_done[%0d]: got %b expected 0", i, init_done); else passes++;
            @(posedge clk);
            #1;
        end
        checks++; if (init_done !== 1'b1) $display("[TB] FAIL mid_sweep_end: got %b expected 1", init_done); else passes++;
        checks++; if (mem_we !== 1'b0) $display("[TB] FAIL mid_sweep_we_end: got %b expected 0", mem_we); else passes++;
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 1'b0, 4'h3, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        #1;
        checks++; if (p0_req_ready !== 1'b1) $display("[TB] FAIL inflight_accept: got %b expected 1", p0_req_ready); else passes++;
        @(posedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (p0_rsp_valid !== 1'b0) $display("[TB] FAIL inflight_p0_rsp[%0d]: got %b expected 0", k, p0_rsp_valid); else passes++;
            checks++; if (p1_rsp_valid !== 1'b0) $display("[TB] FAIL inflight_p1_rsp[%0d]: got %b expected 0", k, p1_rsp_valid); else passes++;
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        test_reset();
        test_sweep();
        test_write_read();
        test_contention();
        test_mixed();
        test_random();
        test_reset_mid_sweep();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
